input_port: RTL and testbench
=============================

# input_port

Bus-side input unit for the 8-bit SAP computer, the counterpart of the output register: it accepts bytes from an external device (switches or a host) over a valid/ready handshake, buffers them in a small FIFO, and drives the oldest byte onto the shared bus when the controller asserts `InEnable`. The controller's IN-type instruction reads the byte through this block. `Empty` lets microcode poll for data.

## Interface
Parameters:
- `DATA_WIDTH`, 8, bus and byte width.
- `DEPTH`, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising `clk` edge.
- `ExtData`  in  DATA_WIDTH  byte offered by the external device.
- `ExtValid`  in  1  `ExtData` is valid this cycle.
- `ExtReady`  out  1  the block can accept a byte this cycle.
- `InEnable`  in  1  controller read strobe: drive the bus and pop the head entry.
- `BusOut`  out  DATA_WIDTH  byte toward the bus mux; head entry while `InEnable` is high, otherwise 0.
- `Empty`  out  1  FIFO holds no entries.
- `Full`  out  1  FIFO holds `DEPTH` entries.
- `Count`  out  $clog2(DEPTH)+1  number of stored entries.
- `Underflow`  out  1  sticky flag: `InEnable` was asserted while `Empty`.

## Operation
- Push: on a rising edge with `ExtValid && ExtReady`, `ExtData` is written at the write pointer. The write pointer advances modulo `DEPTH`.
- `ExtReady` = `!Full`. It is combinational from registered state only and never depends on `ExtValid`.
- Pop: on a rising edge with `InEnable && !Empty`, the read pointer advances modulo `DEPTH`.
- `BusOut` is combinational: `mem[rd_ptr]` when `InEnable && !Empty`, otherwise `8'h00`. The block never tristates.
- Read while empty: `BusOut` = 0. No pointer moves. `Underflow` is set on that edge and stays set until reset.
- Push and pop on the same edge with the FIFO neither empty nor full: both happen and `Count` is unchanged.
- Push while empty with `InEnable` high: the push happens and the pop is blocked. `BusOut` is 0 that cycle and `Underflow` is set. There is no bypass.
- `Count` is updated as +1 on push only, −1 on pop only, and unchanged otherwise. `Empty` = (`Count`==0), `Full` = (`Count`==`DEPTH`).
- Pointers use `$clog2(DEPTH)` bits and wrap naturally. `Count` carries the extra bit to distinguish full from empty.

## Timing
- Reset (`rst`==0 at an edge): pointers = 0, `Count` = 0, `Underflow` = 0. Resulting outputs are `Empty`=1, `Full`=0, `ExtReady`=1, `BusOut`=0.
- Memory contents are not reset.
- Reset has priority over a push or pop on the same edge; both are discarded.
- Reset in the middle of a burst drops all buffered data.
- Latency: a byte pushed at edge N is visible on `BusOut` in the cycle after edge N, provided `InEnable` is high.
- Throughput: one push and one pop per cycle.
- `ExtReady` falls in the cycle after the edge that fills the FIFO. It rises in the cycle after the first pop from full.

## Structure
- Shared package `sap_pkg`: `DATA_WIDTH` constant (8), shared with the output register and the bus mux.
- Sub-module `input_fifo`: a synchronous FIFO holding the storage, pointers and count, exposing `push`, `pop`, `rd_data`, `empty`, `full` and `count`.
- `input_port` adds the handshake, bus gating and the `Underflow` flag.

## Test plan
- Reset: hold `rst`=0 for 2 edges, then release. Required: `Empty`=1, `Full`=0, `ExtReady`=1, `Count`=0, `BusOut`=0, `Underflow`=0.
- Single byte: push `8'h5C` once, then assert `InEnable` one cycle later. Required: `BusOut`=`8'h5C` during the `InEnable` cycle, and `Empty`=1 after that edge.
- Fill and order: push `8'h11`, `22`, `33`, `44` on consecutive edges with `ExtValid` held high. Required: `Full`=1 and `ExtReady`=0 after the 4th edge, and a 5th byte `8'h55` is not accepted. Then pop four times; required `BusOut` sequence is 11, 22, 33, 44.
- Wrap and simultaneous traffic: keep 2 entries stored, then push and pop together for 6 cycles with bytes `8'hA0`–`8'hA5`. Required: `Count` stays 2 and the output order is preserved across the pointer wrap.
- Underflow: assert `InEnable` while empty. Required: `BusOut`=0, `Count`=0, `Underflow`=1 and staying 1 after subsequent pushes and pops, cleared only by `rst`=0.
- Reset mid-burst: push `8'h3C` and `8'h5A`, then drive `rst`=0 on an edge where a push and a pop are also requested. Required: `Count`=0, `Empty`=1, and no byte accepted on that edge.

Source files
------------

// File: rtl/sap_pkg.sv
// Constants shared by the SAP bus-side blocks (input port, output register, bus mux).
package sap_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int IN_FIFO_DEPTH = 4;

  typedef logic [DATA_WIDTH-1:0] bus_byte_t;
endpackage

// File: rtl/input_port_if.sv
// Handshake and status bundle between the input port and its external device/controller.
interface input_port_if #(
  parameter int DATA_WIDTH = sap_pkg::DATA_WIDTH,
  parameter int DEPTH      = sap_pkg::IN_FIFO_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] ExtData;
  logic                  ExtValid;
  logic                  ExtReady;
  logic                  InEnable;
  logic [DATA_WIDTH-1:0] BusOut;
  logic                  Empty;
  logic                  Full;
  logic [CW-1:0]         Count;
  logic                  Underflow;

  modport master (
    output ExtData, ExtValid, InEnable,
    input  ExtReady, BusOut, Empty, Full, Count, Underflow
  );

  modport slave (
    input  ExtData, ExtValid, InEnable,
    output ExtReady, BusOut, Empty, Full, Count, Underflow
  );
endinterface

// File: rtl/input_fifo.sv
// Small synchronous FIFO with combinational head read; callers must not push when full
// or pop when empty.
module input_fifo
  import sap_pkg::*;
#(
  parameter int DW    = sap_pkg::DATA_WIDTH,
  parameter int DEPTH = sap_pkg::IN_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; a push coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (rst && push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_COUNT);
  assign count   = r_count;
endmodule

// File: rtl/input_port.sv
// SAP input port: valid/ready intake into a FIFO, head byte gated onto the bus by InEnable.
module input_port #(
  parameter int DATA_WIDTH = sap_pkg::DATA_WIDTH,
  parameter int DEPTH      = sap_pkg::IN_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input_port_if.slave  port
);
  import sap_pkg::*;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_empty;
  logic                    w_full;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    r_underflow;

  assign w_push = port.ExtValid && !w_full;
  assign w_pop  = port.InEnable && !w_empty;

  input_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (port.ExtData),
    .rd_data (w_rd_data),
    .empty   (w_empty),
    .full    (w_full),
    .count   (w_count)
  );

  // Sticky until reset: any read strobe that finds nothing to read.
  always_ff @(posedge clk) begin
    if (!rst)                            r_underflow <= 1'b0;
    else if (port.InEnable && w_empty)   r_underflow <= 1'b1;
  end

  assign port.ExtReady  = !w_full;
  assign port.BusOut    = w_pop ? w_rd_data : '0;
  assign port.Empty     = w_empty;
  assign port.Full      = w_full;
  assign port.Count     = w_count;
  assign port.Underflow = r_underflow;
endmodule

// File: tb/tb_input_port.sv
// Directed and random stimulus for input_port, checked against a queue-based model.
module tb_input_port;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  input_port_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifc ();

  input_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_q [$];
  logic       model_uf = 1'b0;

  logic [7:0] obs_bus;
  logic       obs_empty, obs_full, obs_ready, obs_uf;
  logic [3:0] obs_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic ie, input logic rn,
                      input string tag);
    int         sz;
    logic [7:0] exp_bus;
    ifc.ExtValid = v;
    ifc.ExtData  = d;
    ifc.InEnable = ie;
    rst          = rn;
    @(negedge clk);
    sz      = model_q.size();
    exp_bus = (ie && sz > 0) ? model_q[0] : 8'h00;
    obs_bus   = ifc.BusOut;
    obs_empty = ifc.Empty;
    obs_full  = ifc.Full;
    obs_ready = ifc.ExtReady;
    obs_uf    = ifc.Underflow;
    obs_count = {1'b0, ifc.Count};
    chk({tag, "_bus"},   32'(obs_bus),   32'(exp_bus));
    chk({tag, "_count"}, 32'(obs_count), 32'(sz));
    chk({tag, "_empty"}, 32'(obs_empty), 32'(sz == 0));
    chk({tag, "_full"},  32'(obs_full),  32'(sz == DEPTH));
    chk({tag, "_ready"}, 32'(obs_ready), 32'(sz != DEPTH));
    chk({tag, "_uf"},    32'(obs_uf),    32'(model_uf));
    $display("%s: v=%0b d=%02h ie=%0b rst=%0b bus=%02h cnt=%0d uf=%0b",
             tag, v, d, ie, rn, obs_bus, obs_count, obs_uf);
    @(posedge clk);
    if (!rn) begin
      model_q.delete();
      model_uf = 1'b0;
    end else begin
      if (ie && sz == 0) model_uf = 1'b1;
      if (ie && sz > 0) void'(model_q.pop_front());
      if (v && sz < DEPTH) model_q.push_back(d);
    end
    #1;
  endtask

  initial begin
    ifc.ExtValid = 1'b0;
    ifc.ExtData  = '0;
    ifc.InEnable = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step(0, 8'h00, 0, 1, "rst");
    chk("rst_empty_k", 32'(obs_empty), 32'd1);
    chk("rst_ready_k", 32'(obs_ready), 32'd1);
    chk("rst_bus_k",   32'(obs_bus),   32'd0);

    // Single byte
    step(1, 8'h5C, 0, 1, "single_push");
    step(0, 8'h00, 1, 1, "single_pop");
    chk("single_bus_k", 32'(obs_bus), 32'h5C);
    step(0, 8'h00, 0, 1, "single_after");
    chk("single_empty_k", 32'(obs_empty), 32'd1);

    // Fill and order
    for (int i = 1; i <= 4; i++) step(1, 8'(i * 8'h11), 0, 1, "fill_push");
    step(1, 8'h55, 0, 1, "fill_extra");
    chk("fill_full_k",  32'(obs_full),  32'd1);
    chk("fill_ready_k", 32'(obs_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 8'h00, 1, 1, "fill_pop");
      chk("fill_order_k", 32'(obs_bus), 32'(i * 8'h11));
    end
    step(0, 8'h00, 0, 1, "fill_drained");
    chk("fill_empty_k", 32'(obs_empty), 32'd1);

    // Wrap with simultaneous push/pop
    step(1, 8'hB0, 0, 1, "wrap_pre");
    step(1, 8'hB1, 0, 1, "wrap_pre");
    for (int i = 0; i < 6; i++) begin
      step(1, 8'hA0 + 8'(i), 1, 1, "wrap_pp");
      chk("wrap_count_k", 32'(obs_count), 32'd2);
    end
    step(0, 8'h00, 1, 1, "wrap_drain");
    chk("wrap_a4_k", 32'(obs_bus), 32'hA4);
    step(0, 8'h00, 1, 1, "wrap_drain");
    chk("wrap_a5_k", 32'(obs_bus), 32'hA5);

    // Underflow, push blocked from bypassing
    step(1, 8'h9E, 1, 1, "uf_read");
    chk("uf_bus_k", 32'(obs_bus), 32'd0);
    step(0, 8'h00, 1, 1, "uf_pop");
    chk("uf_set_k",  32'(obs_uf),  32'd1);
    chk("uf_nobypass_k", 32'(obs_bus), 32'h9E);
    step(1, 8'h12, 0, 1, "uf_hold");
    step(0, 8'h00, 1, 1, "uf_hold");
    chk("uf_sticky_k", 32'(obs_uf), 32'd1);

    // Reset mid-burst with push and pop requested
    step(1, 8'h3C, 0, 1, "mid_push");
    step(1, 8'h5A, 0, 1, "mid_push");
    step(1, 8'h77, 1, 0, "mid_rst");
    step(0, 8'h00, 0, 1, "mid_after");
    chk("mid_count_k", 32'(obs_count), 32'd0);
    chk("mid_empty_k", 32'(obs_empty), 32'd1);
    chk("mid_uf_k",    32'(obs_uf),    32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           8'($urandom),
           ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 3)  ? 1'b0 : 1'b1,
           "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
